// File: rtl/vga_pixel_fifo_if.sv
// Pixel producer write channel into vga_pixel_fifo.
// A word moves on every rising clock edge where wr_valid and wr_ready are both high;
// wr_data must be stable while wr_valid is high, and wr_ready does not depend on wr_valid.
interface vga_pixel_fifo_if;
    logic [11:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;

    modport master (
        output wr_data,
        output wr_valid,
        input  wr_ready
    );

    modport slave (
        input  wr_data,
        input  wr_valid,
        output wr_ready
    );
endinterface

// File: rtl/vga_pixel_fifo.sv
// Show-ahead RGB444 pixel FIFO feeding the VGA timing generator: one pop per visible
// pixel, fixed colour plus sticky flag on underflow, optional flush at each vsync pulse.
module vga_pixel_fifo #(
    parameter int          DEPTH           = 1024,
    parameter logic [11:0] UNDERFLOW_COLOR = 12'h000,
    parameter bit          FLUSH_ON_VSYNC  = 1'b1,
    localparam int         AW              = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset_n,
    vga_pixel_fifo_if.slave   wr,
    input  logic              visible_area,
    input  logic              vsync,
    output logic [11:0]       data,
    output logic [AW:0]       level,
    output logic              underflow,
    input  logic              clear_underflow
);

    logic [11:0] mem [DEPTH];

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        underflow_q, underflow_d;
    logic        vsync_q, vsync_d;

    logic empty;
    logic full;
    logic flush_evt;
    logic push;
    logic pop;

    always_comb begin
        empty     = (wr_ptr_q == rd_ptr_q);
        full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        flush_evt = FLUSH_ON_VSYNC && vsync_q && !vsync;
        // Fullness comes from registered pointers only, so a pop never frees a slot
        // for a push in the same cycle.
        push      = wr.wr_valid && !full;
        pop       = visible_area && !empty && !flush_evt;

        wr_ptr_d = wr_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        rd_ptr_d = rd_ptr_q;
        if (flush_evt) begin
            rd_ptr_d = wr_ptr_q;
        end else if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        underflow_d = underflow_q;
        if (visible_area && empty) begin
            underflow_d = 1'b1;
        end else if (clear_underflow) begin
            underflow_d = 1'b0;
        end

        vsync_d = vsync;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            underflow_q <= 1'b0;
            vsync_q     <= 1'b1;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            underflow_q <= underflow_d;
            vsync_q     <= vsync_d;
        end
    end

    // Storage is deliberately not reset; empty masks whatever it holds.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_q[AW-1:0]] <= wr.wr_data;
        end
    end

    assign data        = empty ? UNDERFLOW_COLOR : mem[rd_ptr_q[AW-1:0]];
    assign level       = wr_ptr_q - rd_ptr_q;
    assign underflow   = underflow_q;
    assign wr.wr_ready = !full;

endmodule

// File: tb/tb_vga_pixel_fifo.sv
// Bench for vga_pixel_fifo: directed scenarios with hand-computed checks plus a
// negedge monitor comparing the DUT against a queue of accepted pixels.
module tb_vga_pixel_fifo;
  localparam int DEPTH = 1024;
  localparam int AW = $clog2(DEPTH);
  localparam logic [11:0] UF_COLOR = 12'h000;
  localparam int FRAME_LINES = 36;
  localparam int FRAME_PIXELS = FRAME_LINES * 640;

  logic clock;
  logic reset_n;
  logic visible_area;
  logic vsync;
  logic [11:0] data;
  logic [AW:0] level;
  logic underflow;
  logic clear_underflow;

  vga_pixel_fifo_if wr_if ();

  vga_pixel_fifo #(
    .DEPTH(DEPTH),
    .UNDERFLOW_COLOR(UF_COLOR),
    .FLUSH_ON_VSYNC(1'b1)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .wr(wr_if),
    .visible_area(visible_area),
    .vsync(vsync),
    .data(data),
    .level(level),
    .underflow(underflow),
    .clear_underflow(clear_underflow)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fails = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scoreboard model
  logic [11:0] exp_q[$];
  logic m_underflow = 1'b0;
  logic m_vsync_prev = 1'b1;
  int pop_count = 0;

  always @(negedge clock) begin
    if (!reset_n) begin
      exp_q.delete();
      m_underflow = 1'b0;
      m_vsync_prev = 1'b1;
    end else begin
      logic flush;
      logic do_pop;
      logic do_push;
      check("data", int'(data), (exp_q.size() > 0) ? int'(exp_q[0]) : int'(UF_COLOR));
      check("level", int'(level), exp_q.size());
      check("wr_ready", int'(wr_if.wr_ready), int'(exp_q.size() < DEPTH));
      check("underflow", int'(underflow), int'(m_underflow));
      flush = m_vsync_prev && !vsync;
      do_pop = visible_area && (exp_q.size() > 0) && !flush;
      do_push = wr_if.wr_valid && (exp_q.size() < DEPTH);
      if (visible_area && exp_q.size() == 0) m_underflow = 1'b1;
      else if (clear_underflow) m_underflow = 1'b0;
      if (flush) exp_q.delete();
      else if (do_pop) begin
        void'(exp_q.pop_front());
        pop_count++;
      end
      if (do_push) exp_q.push_back(wr_if.wr_data);
      m_vsync_prev = vsync;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_word(input logic [11:0] w);
    wr_if.wr_data = w;
    wr_if.wr_valid = 1'b1;
    tick();
    wr_if.wr_valid = 1'b0;
  endtask

  initial begin
    int pushed;
    int pops_before;
    reset_n = 1'b0;
    visible_area = 1'b0;
    vsync = 1'b1;
    clear_underflow = 1'b0;
    wr_if.wr_data = '0;
    wr_if.wr_valid = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    // 1: reset asserted mid-traffic
    wr_if.wr_valid = 1'b1;
    visible_area = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_if.wr_data = 12'(12'h100 + i);
      tick();
    end
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_data", int'(data), 12'h000);
    check("rst_level", int'(level), 0);
    check("rst_wr_ready", int'(wr_if.wr_ready), 1);
    check("rst_underflow", int'(underflow), 0);
    wr_if.wr_valid = 1'b0;
    visible_area = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();

    // 2: three pushes then three pops
    push_word(12'hF00);
    push_word(12'h0F0);
    push_word(12'h00F);
    check("t2_level3", int'(level), 3);
    check("t2_head", int'(data), 12'hF00);
    visible_area = 1'b1;
    check("t2_pop0", int'(data), 12'hF00);
    tick();
    check("t2_pop1", int'(data), 12'h0F0);
    tick();
    check("t2_pop2", int'(data), 12'h00F);
    tick();
    visible_area = 1'b0;
    check("t2_level0", int'(level), 0);
    check("t2_no_underflow", int'(underflow), 0);

    // 3: fill to DEPTH, extra offers ignored, one pop frees one slot
    wr_if.wr_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      wr_if.wr_data = 12'(i);
      tick();
    end
    wr_if.wr_data = 12'hABC;
    repeat (2) tick();
    check("t3_full_level", int'(level), DEPTH);
    check("t3_full_ready", int'(wr_if.wr_ready), 0);
    visible_area = 1'b1;
    tick();
    visible_area = 1'b0;
    wr_if.wr_valid = 1'b0;
    check("t3_level_after_pop", int'(level), DEPTH - 1);
    check("t3_ready_after_pop", int'(wr_if.wr_ready), 1);
    check("t3_head_after_pop", int'(data), 12'h001);
    visible_area = 1'b1;
    repeat (DEPTH - 1) tick();
    visible_area = 1'b0;
    check("t3_drained", int'(level), 0);

    // 4: underflow sticky, set beats clear
    visible_area = 1'b1;
    check("t4_uf_color", int'(data), int'(UF_COLOR));
    tick();
    check("t4_uf_set", int'(underflow), 1);
    visible_area = 1'b0;
    repeat (2) tick();
    check("t4_uf_sticky", int'(underflow), 1);
    visible_area = 1'b1;
    clear_underflow = 1'b1;
    tick();
    check("t4_set_wins", int'(underflow), 1);
    visible_area = 1'b0;
    tick();
    clear_underflow = 1'b0;
    check("t4_cleared", int'(underflow), 0);

    // 5: vsync falling edge flush with a simultaneous push
    push_word(12'h011);
    push_word(12'h022);
    push_word(12'h033);
    push_word(12'h044);
    push_word(12'h055);
    check("t5_level5", int'(level), 5);
    vsync = 1'b0;
    visible_area = 1'b1;
    push_word(12'h5A5);
    visible_area = 1'b0;
    check("t5_flush_level", int'(level), 1);
    check("t5_flush_data", int'(data), 12'h5A5);
    repeat (10) tick();
    push_word(12'h666);
    push_word(12'h777);
    repeat (1600) tick();
    check("t5_held_low_level", int'(level), 3);
    check("t5_held_low_data", int'(data), 12'h5A5);
    vsync = 1'b1;
    tick();
    visible_area = 1'b1;
    check("t5_drain0", int'(data), 12'h5A5);
    tick();
    check("t5_drain1", int'(data), 12'h666);
    tick();
    check("t5_drain2", int'(data), 12'h777);
    tick();
    visible_area = 1'b0;
    check("t5_empty", int'(level), 0);
    check("t5_no_underflow", int'(underflow), 0);

    // 6: shortened frame, 640 visible of 800 clocks per line, producer streaming
    pushed = 0;
    pops_before = pop_count;
    for (int line = -1; line < FRAME_LINES + 4; line++) begin
      for (int h = 0; h < 800; h++) begin
        visible_area = (line >= 0) && (line < FRAME_LINES) && (h < 640);
        vsync = !((line == FRAME_LINES + 1) || (line == FRAME_LINES + 2));
        wr_if.wr_valid = (pushed < FRAME_PIXELS);
        wr_if.wr_data = 12'(pushed * 7);
        if (wr_if.wr_valid && wr_if.wr_ready) begin
          tick();
          pushed++;
        end else begin
          tick();
        end
      end
    end
    visible_area = 1'b0;
    wr_if.wr_valid = 1'b0;
    vsync = 1'b1;
    tick();
    check("t6_pushed", pushed, FRAME_PIXELS);
    check("t6_popped", pop_count - pops_before, FRAME_PIXELS);
    check("t6_underflow", int'(underflow), 0);
    check("t6_level", int'(level), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
